alu_result_buffer: RTL and testbench

ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

---
 rtl/alu_result_buffer.sv | 93 +++++++++
 tb/tb_alu_result_buffer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_buffer.sv
// Small in-order FIFO between the ALU and writeback, with a forwarding lookup
// that returns the youngest buffered result for a source register.
module alu_result_buffer #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned DEPTH          = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_flush,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [DATA_WIDTH-1:0]       i_result,
  input  logic [REG_ADDR_WIDTH-1:0]   i_rd,
  input  logic                        i_wb_en,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [DATA_WIDTH-1:0]       o_result,
  output logic [REG_ADDR_WIDTH-1:0]   o_rd,
  output logic                        o_wb_en,
  output logic [$clog2(DEPTH):0]      o_count,
  input  logic [REG_ADDR_WIDTH-1:0]   i_fwd_rs,
  output logic                        o_fwd_hit,
  output logic [DATA_WIDTH-1:0]       o_fwd_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0]     mem_result [DEPTH];
  logic [REG_ADDR_WIDTH-1:0] mem_rd     [DEPTH];
  logic                      mem_wb_en  [DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;
  logic [PTR_W-1:0] fwd_idx;

  assign o_count = count;
  assign o_ready = (count < CNT_W'(DEPTH));
  assign o_valid = (count != '0);
  assign push    = i_valid && o_ready && !i_flush;
  assign pop     = o_valid && i_ready && !i_flush;

  // Pointers and occupancy; flush wins over any same-cycle push or pop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (i_flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Entry storage needs no reset: slots beyond count are never observed.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_result[wr_ptr] <= i_result;
      mem_rd[wr_ptr]     <= i_rd;
      mem_wb_en[wr_ptr]  <= i_wb_en;
    end
  end

  assign o_result = o_valid ? mem_result[rd_ptr] : '0;
  assign o_rd     = o_valid ? mem_rd[rd_ptr]     : '0;
  assign o_wb_en  = o_valid ? mem_wb_en[rd_ptr]  : 1'b0;

  // Walk from oldest to youngest so the last match found is the youngest.
  always_comb begin
    o_fwd_hit  = 1'b0;
    o_fwd_data = '0;
    fwd_idx    = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      fwd_idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && mem_wb_en[fwd_idx] &&
          (mem_rd[fwd_idx] == i_fwd_rs) && (i_fwd_rs != '0)) begin
        o_fwd_hit  = 1'b1;
        o_fwd_data = mem_result[fwd_idx];
      end
    end
  end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Bench for alu_result_buffer: directed scenarios plus random traffic, all
// checked against a queue-based model of the buffer contents.
module tb_alu_result_buffer;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] rd;
    logic          wb;
  } entry_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          out_ready_dut;
  logic [DW-1:0] in_result;
  logic [AW-1:0] in_rd;
  logic          in_wb_en;
  logic          out_valid;
  logic          wb_ready;
  logic [DW-1:0] out_result;
  logic [AW-1:0] out_rd;
  logic          out_wb_en;
  logic [CW-1:0] out_count;
  logic [AW-1:0] fwd_rs;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;

  entry_t q[$];
  int     total = 0;
  int     bad   = 0;

  always #5 clk = ~clk;

  alu_result_buffer #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(in_valid),
    .o_ready(out_ready_dut), .i_result(in_result), .i_rd(in_rd), .i_wb_en(in_wb_en),
    .o_valid(out_valid), .i_ready(wb_ready), .o_result(out_result), .o_rd(out_rd),
    .o_wb_en(out_wb_en), .o_count(out_count), .i_fwd_rs(fwd_rs),
    .o_fwd_hit(fwd_hit), .o_fwd_data(fwd_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Youngest stored entry that writes rs wins; register 0 never forwards.
  function automatic void model_fwd(input logic [AW-1:0] rs, output logic hit,
                                    output logic [DW-1:0] data);
    hit  = 1'b0;
    data = '0;
    if (rs != '0) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].wb && q[i].rd == rs) begin
          hit  = 1'b1;
          data = q[i].data;
          break;
        end
      end
    end
  endfunction

  task automatic check_all();
    logic          h;
    logic [DW-1:0] d;
    model_fwd(fwd_rs, h, d);
    check("count",    64'(out_count),     64'(q.size()));
    check("ready",    64'(out_ready_dut), 64'(q.size() < DEPTH));
    check("valid",    64'(out_valid),     64'(q.size() != 0));
    check("result",   64'(out_result),    q.size() != 0 ? 64'(q[0].data) : 64'd0);
    check("rd",       64'(out_rd),        q.size() != 0 ? 64'(q[0].rd)   : 64'd0);
    check("wb_en",    64'(out_wb_en),     q.size() != 0 ? 64'(q[0].wb)   : 64'd0);
    check("fwd_hit",  64'(fwd_hit),       64'(h));
    check("fwd_data", 64'(fwd_data),      64'(d));
  endtask

  // One clock: drive inputs, check before the edge, then advance the model.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic [AW-1:0] rd,
                      input logic wb, input logic rdy, input logic fl, input logic [AW-1:0] rs);
    entry_t e;
    logic   do_push;
    logic   do_pop;
    in_valid  = v;
    in_result = d;
    in_rd     = rd;
    in_wb_en  = wb;
    wb_ready  = rdy;
    flush     = fl;
    fwd_rs    = rs;
    #3;
    check_all();
    do_push = v && (q.size() < DEPTH) && !fl;
    do_pop  = (q.size() != 0) && rdy && !fl;
    e = '{data: d, rd: rd, wb: wb};
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(e);
    end
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, '0, '0, 1'b0, rdy, 1'b0, '0);
  endtask

  task automatic drain();
    for (int i = 0; i < int'(DEPTH) + 1; i++) idle(1'b1);
  endtask

  initial begin
    logic [DW-1:0] exp_seq [4];
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_result = '0; in_rd = '0;
    in_wb_en = 1'b0; wb_ready = 1'b0; fwd_rs = '0;
    #2;
    check_all();
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill to full, a fifth push is refused, then drain in order.
    for (int i = 0; i < 4; i++) step(1'b1, DW'(32'h11 * (i + 1)), AW'(i + 1), 1'b1, 1'b0, 1'b0, '0);
    check("full_count", 64'(out_count), 64'd4);
    check("full_ready", 64'(out_ready_dut), 64'd0);
    step(1'b1, 32'h55, 5'd9, 1'b1, 1'b0, 1'b0, '0);
    check("no_5th", 64'(out_count), 64'd4);
    exp_seq = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int i = 0; i < 4; i++) begin
      check("drain_order", 64'(out_result), 64'(exp_seq[i]));
      idle(1'b1);
    end
    check("drained", 64'(out_count), 64'd0);

    // Single-entry latency.
    step(1'b1, 32'hAB, 5'd7, 1'b1, 1'b1, 1'b0, '0);
    check("lat_valid", 64'(out_valid), 64'd1);
    check("lat_data", 64'(out_result), 64'hAB);
    idle(1'b1);
    check("lat_gone", 64'(out_valid), 64'd0);

    // Steady push/pop at count 2 across pointer wrap.
    step(1'b1, 32'h100, 5'd1, 1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 32'h101, 5'd2, 1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 10; i++) begin
      check("steady_head", 64'(out_result), 64'(32'h100 + i));
      step(1'b1, DW'(32'h102 + i), AW'(i), 1'b1, 1'b1, 1'b0, '0);
      check("steady_cnt", 64'(out_count), 64'd2);
    end
    drain();

    // Forwarding picks youngest writing match; rs=0 never hits.
    step(1'b1, 32'h10, 5'd5, 1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 32'h20, 5'd5, 1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 32'h30, 5'd5, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 32'h40, 5'd0, 1'b1, 1'b0, 1'b0, '0);
    fwd_rs = 5'd5; #1;
    check("fwd5_hit", 64'(fwd_hit), 64'd1);
    check("fwd5_data", 64'(fwd_data), 64'h20);
    fwd_rs = 5'd0; #1;
    check("fwd0_hit", 64'(fwd_hit), 64'd0);
    drain();

    // Flush beats a same-cycle push and pop.
    for (int i = 0; i < 3; i++) step(1'b1, DW'(32'h70 + i), 5'd3, 1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 32'h77, 5'd3, 1'b1, 1'b1, 1'b1, '0);
    check("flush_cnt", 64'(out_count), 64'd0);
    check("flush_vld", 64'(out_valid), 64'd0);
    idle(1'b0);

    // Asynchronous reset mid-operation, held across an edge with a push offered.
    step(1'b1, 32'h61, 5'd1, 1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 32'h62, 5'd2, 1'b1, 1'b0, 1'b0, '0);
    #2;
    rst_n = 1'b0; in_valid = 1'b1; wb_ready = 1'b1; fwd_rs = 5'd1;
    #1;
    q.delete();
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_count", 64'(out_count), 64'd0);
    check("arst_ready", 64'(out_ready_dut), 64'd1);
    check("arst_fwd", 64'(fwd_hit), 64'd0);
    @(posedge clk); #1;
    check("arst_hold", 64'(out_count), 64'd0);
    in_valid = 1'b0; #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    step(1'b1, 32'h55, 5'd4, 1'b1, 1'b0, 1'b0, '0);
    check("post_rst_head", 64'(out_result), 64'h55);
    drain();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), $urandom, AW'($urandom_range(0, 7)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 31) == 0), AW'($urandom_range(0, 7)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
